// File: rtl/fetch_unit.sv
// Instruction fetch engine: assembles INSTR_BYTES-byte instructions from sequential
// byte reads and presents them on a valid/ready handshake, with PC-relative redirect.
module fetch_unit #(
   parameter int                    ADDR_WIDTH   = 16,
   parameter int                    INSTR_BYTES  = 2,
   parameter int                    MEM_LATENCY  = 1,
   parameter bit                    BIG_ENDIAN   = 1'b0,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      mem_re,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   input  logic [7:0]                mem_q,
   output logic [8*INSTR_BYTES-1:0]  instr,
   output logic [ADDR_WIDTH-1:0]     instr_pc,
   output logic                      instr_valid,
   input  logic                      instr_ready,
   input  logic                      halt,
   input  logic                      br_valid,
   input  logic [7:0]                br_off
);

   localparam int IDX_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
   localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(INSTR_BYTES - 1);
   localparam logic [LAT_W-1:0]      LAT_LAST = LAT_W'(MEM_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(INSTR_BYTES);

   typedef enum logic [1:0] {IDLE, ADDR, WAIT, VALID} state_t;

   state_t                               state_q, state_d;
   logic [ADDR_WIDTH-1:0]                pc_q, pc_d;
   logic [IDX_W-1:0]                     idx_q, idx_d;
   logic [LAT_W-1:0]                     lat_q, lat_d;
   logic                                 mem_re_q, mem_re_d;
   logic [ADDR_WIDTH-1:0]                mem_addr_q, mem_addr_d;
   logic [INSTR_BYTES-1:0][7:0]          instr_q, instr_d;
   logic                                 valid_q, valid_d;
   logic [IDX_W-1:0]                     slot;
   logic                                 restart;

   // Signed instruction-unit offset scaled to bytes, wrapped to the address width.
   function automatic logic [ADDR_WIDTH-1:0] scale_off(input logic [7:0] off);
      logic signed [ADDR_WIDTH+31:0] a, b, p;
      a = (ADDR_WIDTH+32)'($signed(off));
      b = (ADDR_WIDTH+32)'(INSTR_BYTES);
      p = a * b;
      return p[ADDR_WIDTH-1:0];
   endfunction

   assign slot = BIG_ENDIAN ? (IDX_LAST - idx_q) : idx_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      idx_d      = idx_q;
      lat_d      = lat_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      mem_addr_d = mem_addr_q;
      restart    = 1'b0;

      if (br_valid) begin
         // Redirect drops any partial instruction and any byte still in flight.
         pc_d    = pc_q + scale_off(br_off);
         idx_d   = '0;
         lat_d   = '0;
         valid_d = 1'b0;
         restart = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (!halt) state_d = ADDR;
            end
            ADDR: begin
               lat_d   = '0;
               state_d = WAIT;
            end
            WAIT: begin
               if (lat_q == LAT_LAST) begin
                  instr_d[slot] = mem_q;
                  lat_d         = '0;
                  if (idx_q == IDX_LAST) begin
                     idx_d   = '0;
                     valid_d = 1'b1;
                     state_d = VALID;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     state_d = ADDR;
                  end
               end else begin
                  lat_d = lat_q + 1'b1;
               end
            end
            VALID: begin
               if (instr_ready) begin
                  pc_d    = pc_q + STEP;
                  valid_d = 1'b0;
                  restart = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (restart) state_d = halt ? IDLE : ADDR;

      // ADDR lasts one cycle, so every entry into it is a fresh read.
      mem_re_d = (state_d == ADDR);
      if (mem_re_d) mem_addr_d = pc_d + ADDR_WIDTH'(idx_d);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_VECTOR;
         idx_q      <= '0;
         lat_q      <= '0;
         mem_re_q   <= 1'b0;
         mem_addr_q <= RESET_VECTOR;
         instr_q    <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         idx_q      <= idx_d;
         lat_q      <= lat_d;
         mem_re_q   <= mem_re_d;
         mem_addr_q <= mem_addr_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
      end
   end

   assign mem_re      = mem_re_q;
   assign mem_addr    = mem_addr_q;
   assign instr       = instr_q;
   assign instr_pc    = pc_q;
   assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a default instance and a 3-byte/latency-2/big-endian instance
// share stimulus and are each compared every cycle against a transaction-level model.
module tb_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, halt, rdy, br_valid;
   logic [7:0]  br_off;
   logic        re0, re1, v0, v1;
   logic [15:0] addr0, addr1, ipc0, ipc1, ins0;
   logic [23:0] ins1;
   logic [7:0]  q0, q1, q1_s;
   logic [7:0]  mem0 [65536];
   logic [7:0]  mem1 [65536];

   int n_cmp = 0;
   int n_err = 0;

   fetch_unit u_dut0 (
      .clk(clk), .rst(rst), .mem_re(re0), .mem_addr(addr0), .mem_q(q0),
      .instr(ins0), .instr_pc(ipc0), .instr_valid(v0), .instr_ready(rdy),
      .halt(halt), .br_valid(br_valid), .br_off(br_off));

   fetch_unit #(.ADDR_WIDTH(16), .INSTR_BYTES(3), .MEM_LATENCY(2), .BIG_ENDIAN(1'b1),
                .RESET_VECTOR(16'hFFFE)) u_dut1 (
      .clk(clk), .rst(rst), .mem_re(re1), .mem_addr(addr1), .mem_q(q1),
      .instr(ins1), .instr_pc(ipc1), .instr_valid(v1), .instr_ready(rdy),
      .halt(halt), .br_valid(br_valid), .br_off(br_off));

   // Memories return garbage on cycles whose read was not strobed.
   always @(posedge clk) begin
      q0   <= re0 ? mem0[addr0] : 8'($urandom);
      q1_s <= re1 ? mem1[addr1] : 8'($urandom);
      q1   <= q1_s;
   end

   int          m_pc[2], m_el[2], m_addr[2];
   bit          m_fetch[2], m_valid[2], m_re[2], m_rstf[2];
   logic [31:0] m_instr[2];

   function automatic int ib(int i);  return (i != 0) ? 3 : 2;  endfunction
   function automatic int lat(int i); return (i != 0) ? 2 : 1;  endfunction
   function automatic int rv(int i);  return (i != 0) ? 'hFFFE : 0; endfunction

   function automatic logic [31:0] assemble(int i, int pc);
      logic [31:0] res = '0;
      logic [7:0]  b;
      int          slot;
      for (int k = 0; k < ib(i); k++) begin
         b    = (i != 0) ? mem1[16'((pc + k) & 'hFFFF)] : mem0[16'((pc + k) & 'hFFFF)];
         slot = (i != 0) ? (ib(i) - 1 - k) : k;
         res  = res | (32'(b) << (8 * slot));
      end
      return res;
   endfunction

   // One clock of the model: a fetch is a run of ib*(1+lat) cycles with a read
   // at the start of every (1+lat)-cycle slot.
   task automatic model_step(int i);
      int per   = 1 + lat(i);
      bit start = 1'b0;
      if (!rst) begin
         m_fetch[i] = 0; m_valid[i] = 0; m_re[i] = 0; m_rstf[i] = 1;
         m_pc[i] = rv(i); m_addr[i] = rv(i); m_instr[i] = '0;
      end else begin
         m_rstf[i] = 0;
         if (br_valid) begin
            m_pc[i] = (m_pc[i] + int'($signed(br_off)) * ib(i)) & 'hFFFF;
            m_valid[i] = 0; m_fetch[i] = 0; start = !halt;
         end else if (m_valid[i] && rdy) begin
            m_pc[i] = (m_pc[i] + ib(i)) & 'hFFFF;
            m_valid[i] = 0; start = !halt;
         end else if (m_fetch[i]) begin
            m_el[i]++;
            if (m_el[i] == ib(i) * per) begin
               m_fetch[i] = 0; m_valid[i] = 1;
               m_instr[i] = assemble(i, m_pc[i]);
            end
         end else if (!m_valid[i]) begin
            start = !halt;
         end
         if (start) begin m_fetch[i] = 1; m_el[i] = 0; end
         m_re[i] = m_fetch[i] && (m_el[i] % per == 0);
         if (m_re[i]) m_addr[i] = (m_pc[i] + m_el[i] / per) & 'hFFFF;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("re0", 32'(re0), 32'(m_re[0]));
      chk("addr0", 32'(addr0), 32'(m_addr[0]));
      chk("valid0", 32'(v0), 32'(m_valid[0]));
      if (m_valid[0] || m_rstf[0]) begin
         chk("instr0", 32'(ins0), m_instr[0]);
         chk("pc0", 32'(ipc0), 32'(m_pc[0]));
      end
      chk("re1", 32'(re1), 32'(m_re[1]));
      chk("addr1", 32'(addr1), 32'(m_addr[1]));
      chk("valid1", 32'(v1), 32'(m_valid[1]));
      if (m_valid[1] || m_rstf[1]) begin
         chk("instr1", 32'(ins1), m_instr[1]);
         chk("pc1", 32'(ipc1), 32'(m_pc[1]));
      end
   endtask

   // Drive one cycle of inputs, advance the model, then compare mid-cycle.
   task automatic cyc(input bit r, input bit h, input bit rd, input bit bv, input logic [7:0] bo);
      rst = r; halt = h; rdy = rd; br_valid = bv; br_off = bo;
      model_step(0);
      model_step(1);
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_v0(input bit h, input bit rd, input int maxc);
      int n = 0;
      while (!v0 && n < maxc) begin
         cyc(1, h, rd, 0, 8'h00);
         n++;
      end
      chk("wait_valid0", 32'(v0), 32'd1);
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) begin
         mem0[a] = 8'($urandom);
         mem1[a] = 8'($urandom);
      end
      mem0[0] = 8'h34; mem0[1] = 8'h12;
      mem1[16'hFFFE] = 8'hAA; mem1[16'hFFFF] = 8'hBB; mem1[0] = 8'hCC;

      // Reset, latency, back-pressure
      cyc(0, 0, 0, 0, 8'h00);
      cyc(0, 0, 0, 0, 8'h00);
      chk("rst_addr1", 32'(addr1), 32'hFFFE);
      for (int c = 1; c <= 12; c++) begin
         cyc(1, 0, 0, 0, 8'h00);
         if (c == 4) chk("lat_v0_c4", 32'(v0), 32'd0);
         if (c == 5) begin
            chk("lat_v0_c5", 32'(v0), 32'd1);
            chk("instr_1234", 32'(ins0), 32'h1234);
            chk("ipc_0000", 32'(ipc0), 32'h0000);
         end
         if (c > 5) begin
            chk("bp_re0", 32'(re0), 32'd0);
            chk("bp_instr0", 32'(ins0), 32'h1234);
         end
         if (c == 9) chk("lat_v1_c9", 32'(v1), 32'd0);
         if (c == 10) begin
            chk("lat_v1_c10", 32'(v1), 32'd1);
            chk("instr_aabbcc", 32'(ins1), 32'hAABBCC);
            chk("ipc_fffe", 32'(ipc1), 32'hFFFE);
         end
      end
      cyc(1, 0, 1, 0, 8'h00);
      chk("next_addr0", 32'(addr0), 32'h0002);
      chk("next_re0", 32'(re0), 32'd1);
      chk("wrap_addr1", 32'(addr1), 32'h0001);

      // Redirects
      cyc(0, 0, 0, 0, 8'h00);
      wait_v0(0, 0, 20);
      cyc(1, 0, 0, 1, 8'h08);
      chk("br_to_0010", 32'(addr0), 32'h0010);
      wait_v0(0, 0, 20);
      chk("ipc_0010", 32'(ipc0), 32'h0010);
      cyc(1, 0, 1, 1, 8'hFE);
      chk("br_acc_000c", 32'(addr0), 32'h000C);
      wait_v0(0, 0, 20);
      cyc(1, 0, 0, 1, 8'h02);
      wait_v0(0, 0, 20);
      cyc(1, 0, 0, 1, 8'h03);
      chk("br_to_0016", 32'(addr0), 32'h0016);
      wait_v0(0, 0, 20);
      cyc(1, 0, 0, 1, 8'h05);
      chk("br_to_0020", 32'(addr0), 32'h0020);
      cyc(1, 0, 0, 0, 8'h00);
      cyc(1, 0, 0, 1, 8'h01);
      chk("midfetch_0022", 32'(addr0), 32'h0022);
      wait_v0(0, 0, 20);
      chk("ipc_0022", 32'(ipc0), 32'h0022);
      chk("instr_0022", 32'(ins0), {16'h0, mem0[16'h0023], mem0[16'h0022]});

      // Reset in the middle of a fetch
      cyc(1, 0, 0, 1, 8'h00);
      cyc(1, 0, 0, 0, 8'h00);
      cyc(0, 0, 0, 0, 8'h00);
      chk("rstw_valid0", 32'(v0), 32'd0);
      chk("rstw_re0", 32'(re0), 32'd0);
      chk("rstw_addr0", 32'(addr0), 32'h0000);
      chk("rstw_instr0", 32'(ins0), 32'h0000);

      // Halt
      for (int c = 0; c < 10; c++) begin
         cyc(1, 1, 0, 0, 8'h00);
         chk("halt_re0", 32'(re0), 32'd0);
      end
      cyc(1, 0, 0, 0, 8'h00);
      cyc(1, 1, 0, 0, 8'h00);
      wait_v0(1, 0, 20);
      chk("halt_ipc0", 32'(ipc0), 32'h0000);
      cyc(1, 1, 1, 0, 8'h00);
      for (int c = 0; c < 5; c++) begin
         cyc(1, 1, 0, 0, 8'h00);
         chk("halt_idle_re0", 32'(re0), 32'd0);
      end
      cyc(1, 0, 0, 0, 8'h00);
      chk("unhalt_addr0", 32'(addr0), 32'h0002);
      chk("unhalt_re0", 32'(re0), 32'd1);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         cyc(($urandom_range(99) != 0), ($urandom_range(7) == 0), 1'($urandom_range(1)),
             ($urandom_range(15) == 0), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
